rom_burst_arbiter: RTL and testbench
====================================

Name: rom_burst_arbiter

Overview:
- Sequencing controller and round-robin arbiter that shares one ROM_16x8-style ROM between two requesters.
- The ROM is combinational read, with chip select, read enable, 4-bit address and 8-bit data.
- Each requester asks for a burst of 1..16 consecutive bytes starting at a given address.
- The block grants one requester, drives the ROM one address per cycle, and returns registered data tagged with requester id and last flag.

Parameters:
- ADDR_W, 4, ROM address width; burst length field uses the same width.
- DATA_W, 8, ROM data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 burst request (level, held until gnt0)
- addr0  input  ADDR_W  requester 0 start address
- len0  input  ADDR_W  requester 0 burst length minus 1 (0 = 1 byte, 15 = 16 bytes)
- gnt0  output  1  one-cycle pulse: requester 0 burst accepted
- req1 / addr1 / len1  input  1 / ADDR_W / ADDR_W  requester 1, same semantics
- gnt1  output  1  one-cycle pulse: requester 1 burst accepted
- rd_data  output  DATA_W  registered ROM byte
- rd_vld  output  1  rd_data valid this cycle
- rd_id  output  1  requester owning rd_data
- rd_last  output  1  rd_data is the final byte of the burst
- busy  output  1  burst in progress (state READ)
- rom_cs  output  1  ROM chip select
- rom_read_en  output  1  ROM read enable
- rom_addr  output  ADDR_W  ROM address
- rom_data  input  DATA_W  ROM read data, combinational from rom_addr

Behaviour:
- Reset values: all outputs 0, state IDLE, cur_id 0, count 0, cur_addr 0, last_id 1 (requester 0 wins first).
- Reset mid-burst aborts the burst; no further rd_vld after the reset cycle.
- FSM states IDLE and READ.
- In IDLE with no req: remain IDLE.
- In IDLE with any req: select winner.
  - Single requester wins outright.
  - If both request, the requester != last_id wins.
  - Latch cur_id, cur_addr=addrN, count=lenN, last_id=winner.
  - Pulse gntN for this cycle; next state READ.
- In READ: rom_cs=1, rom_read_en=1, rom_addr=cur_addr. All three decode combinationally from state; they are 0 and rom_addr=0 in IDLE.
- At each READ clock edge, register:
  - rd_data<=rom_data, rd_vld<=1, rd_id<=cur_id, rd_last<=(count==0).
  - If count==0: next state IDLE. Otherwise cur_addr<=cur_addr+1 (wraps 15->0, mod 2^ADDR_W) and count<=count-1.
- rd_vld/rd_data/rd_id/rd_last are 0/held-0 in any cycle not following a READ cycle. rd_data clears to 0 when rd_vld=0.
- Latency:
  - gnt at cycle T; first ROM access at T+1; first rd_vld at T+2.
  - A burst of N bytes yields rd_vld on N consecutive cycles.
- Throughput: the IDLE arbitration cycle between bursts gives N data beats per N+1 cycles under continuous demand.
- req/addr/len are sampled only in the gnt cycle. Changes while busy are ignored. A requester must hold req until its gnt, and deassert or re-present a new burst the cycle after gnt.
- A req still high after gnt is treated as a new request at the next IDLE.
- busy=1 exactly in READ cycles.
- gnt0 and gnt1 are never high together.

Decomposition:
- Shared package: state encoding (IDLE, READ), ADDR_W/DATA_W defaults, requester id constants (ID0=0, ID1=1).
- One natural sub-module: rr_arb2, a 2-way round-robin pick. Inputs req0, req1, last_id; outputs gnt_vec and win_id; combinational.
- Top holds the FSM, counters and output registers.

Test Plan:
- Bench ROM model: mem[i]=i*8'h11.
- Reset then idle 5 cycles -> all outputs 0, rom_cs=0, rom_read_en=0.
- req0=1, addr0=7, len0=0 -> gnt0 pulse at T; rom_addr=7, rom_cs=1 at T+1; at T+2 rd_vld=1, rd_data=8'h77, rd_id=0, rd_last=1; busy high one cycle.
- req1=1, addr1=14, len1=3 -> rom_addr 14,15,0,1 on consecutive cycles; rd_data 8'hEE,8'hFF,8'h00,8'h11; rd_last only on 8'h11; rd_id=1.
- req0 and req1 held high continuously, both len=1, addr0=0, addr1=8 -> grants alternate 0,1,0,1 starting with 0. Data 00,11 then 88,99 repeating; one idle cycle between bursts.
- rst asserted on the third beat of a len=15 burst -> next cycle all outputs 0, state IDLE; no rd_vld afterward until a new gnt.
- req0 high, addr0 changed from 3 to 9 while busy with requester 1 -> requester 0 burst uses the addr0 value sampled at its gnt cycle (9).

Source files
------------

// File: rtl/rom_burst_arbiter_pkg.sv
// Shared definitions for the two-requester burst arbiter in front of a 16x8 ROM.
// State encoding, default widths and requester ids live here.
package rom_burst_arbiter_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Bundle of requester handshakes, read-return bus and ROM port for rom_burst_arbiter.
// slave is the arbiter side; master is the side driving requests and the ROM data.
interface rom_burst_arbiter_if
  import rom_burst_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] len0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] len1;
  logic              gnt1;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              rd_id;
  logic              rd_last;
  logic              busy;
  logic              rom_cs;
  logic              rom_read_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0, addr0, len0, req1, addr1, len1, rom_data,
    output gnt0, gnt1, rd_data, rd_vld, rd_id, rd_last, busy,
           rom_cs, rom_read_en, rom_addr
  );

  modport master (
    output req0, addr0, len0, req1, addr1, len1, rom_data,
    input  gnt0, gnt1, rd_data, rd_vld, rd_id, rd_last, busy,
           rom_cs, rom_read_en, rom_addr
  );

endinterface

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on contention the one that
// did not win last time wins.
module rr_arb2
  import rom_burst_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_id,
  output logic [1:0] gnt_vec,
  output logic       win_id
);

  always_comb begin
    gnt_vec = 2'b00;
    win_id  = ID0;
    if (req0 && req1) begin
      win_id = ~last_id;
    end else if (req1) begin
      win_id = ID1;
    end
    if (req0 || req1) begin
      gnt_vec = (win_id == ID1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Burst sequencer sharing one combinational ROM between two requesters: arbitrate in
// IDLE, then walk the ROM one address per cycle and return registered, tagged bytes.
module rom_burst_arbiter
  import rom_burst_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic               clk,
  input  logic               rst,
  rom_burst_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              cur_id_q, cur_id_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              last_id_q, last_id_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_id_q, rd_id_d;
  logic              rd_last_q, rd_last_d;
  logic [1:0]        arb_gnt;
  logic              arb_win;
  logic [1:0]        gnt_vec;
  logic              in_read;

  rr_arb2 u_arb (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .last_id (last_id_q),
    .gnt_vec (arb_gnt),
    .win_id  (arb_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_id_q   <= ID0;
      cur_addr_q <= '0;
      count_q    <= '0;
      last_id_q  <= ID1;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      last_id_q  <= last_id_d;
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Return registers default to zero so they only carry data the cycle after a READ.
  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    last_id_d  = last_id_q;
    rd_data_d  = '0;
    rd_vld_d   = 1'b0;
    rd_id_d    = 1'b0;
    rd_last_d  = 1'b0;
    gnt_vec    = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_vec    = arb_gnt;
          cur_id_d   = arb_win;
          cur_addr_d = (arb_win == ID1) ? bus.addr1 : bus.addr0;
          count_d    = (arb_win == ID1) ? bus.len1 : bus.len0;
          last_id_d  = arb_win;
          state_d    = READ;
        end
      end
      READ: begin
        rd_vld_d  = 1'b1;
        rd_data_d = bus.rom_data;
        rd_id_d   = cur_id_q;
        rd_last_d = (count_q == '0);
        if (count_q == '0) begin
          state_d = IDLE;
        end else begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          count_d    = count_q - ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are suppressed while reset is asserted so nothing is accepted that reset discards.
  assign in_read         = (state_q == READ);
  assign bus.gnt0        = gnt_vec[0] & ~rst;
  assign bus.gnt1        = gnt_vec[1] & ~rst;
  assign bus.busy        = in_read;
  assign bus.rom_cs      = in_read;
  assign bus.rom_read_en = in_read;
  assign bus.rom_addr    = in_read ? cur_addr_q : '0;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_vld      = rd_vld_q;
  assign bus.rd_id       = rd_id_q;
  assign bus.rd_last     = rd_last_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a burst-level reference model.
module tb_rom_burst_arbiter;
  import rom_burst_arbiter_pkg::*;

  typedef struct {
    logic       req0;
    logic [3:0] addr0;
    logic [3:0] len0;
    logic       req1;
    logic [3:0] addr1;
    logic [3:0] len1;
    logic [19:0] exp_out;
  } vec_t;

  logic clk;
  logic rst;
  rom_burst_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

  rom_burst_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic logic [7:0] rom_byte(input logic [3:0] a);
    return 8'(a) * 8'h11;
  endfunction

  assign bus_if.rom_data = rom_byte(bus_if.rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit do_check = 1'b0;

  // Reference model: a burst is {base, len, id}; rem counts READ cycles still to run.
  int         rem = 0;
  logic [3:0] m_base = '0;
  logic [3:0] m_len = '0;
  logic       m_id = 1'b0;
  logic       m_last = 1'b1;
  logic       m_g0, m_g1, m_win;
  logic       e_vld = 1'b0, e_id = 1'b0, e_last = 1'b0;
  logic [7:0] e_data = '0;

  logic seen_g0, seen_g1, seen_vld, seen_id;
  logic [7:0] seen_data;

  vec_t vecs[$];

  function automatic logic [19:0] pack_out(input logic g0, g1, bsy, input logic [3:0] ra,
                                           input logic vld, input logic [7:0] d,
                                           input logic id, last);
    return {g0, g1, bsy, bsy, bsy, ra, vld, d, id, last};
  endfunction

  function automatic logic [19:0] dut_out();
    return {bus_if.gnt0, bus_if.gnt1, bus_if.busy, bus_if.rom_cs, bus_if.rom_read_en,
            bus_if.rom_addr, bus_if.rd_vld, bus_if.rd_data, bus_if.rd_id, bus_if.rd_last};
  endfunction

  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic r0, input logic [3:0] a0, l0, input logic r1,
                        input logic [3:0] a1, l1, input logic [19:0] e);
    vec_t v;
    v.req0 = r0; v.addr0 = a0; v.len0 = l0;
    v.req1 = r1; v.addr1 = a1; v.len1 = l1;
    v.exp_out = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus_if.req0 = v.req0; bus_if.addr0 = v.addr0; bus_if.len0 = v.len0;
    bus_if.req1 = v.req1; bus_if.addr1 = v.addr1; bus_if.len1 = v.len1;
  endtask

  task automatic checkOutput();
    int idx;
    logic       e_busy;
    logic [3:0] e_addr;
    e_busy = (rem > 0);
    idx    = int'(m_len) + 1 - rem;
    e_addr = e_busy ? 4'((int'(m_base) + idx) % 16) : 4'h0;
    m_g0 = 1'b0; m_g1 = 1'b0; m_win = 1'b0;
    if (!rst && rem == 0 && (bus_if.req0 || bus_if.req1)) begin
      m_win = (bus_if.req0 && bus_if.req1) ? ~m_last : bus_if.req1;
      m_g0  = ~m_win;
      m_g1  = m_win;
    end
    if (do_check) begin
      checkField("gnt0", 32'(bus_if.gnt0), 32'(m_g0));
      checkField("gnt1", 32'(bus_if.gnt1), 32'(m_g1));
      checkField("busy", 32'(bus_if.busy), 32'(e_busy));
      checkField("rom_cs", 32'(bus_if.rom_cs), 32'(e_busy));
      checkField("rom_read_en", 32'(bus_if.rom_read_en), 32'(e_busy));
      checkField("rom_addr", 32'(bus_if.rom_addr), 32'(e_addr));
      checkField("rd_vld", 32'(bus_if.rd_vld), 32'(e_vld));
      checkField("rd_data", 32'(bus_if.rd_data), 32'(e_data));
      checkField("rd_id", 32'(bus_if.rd_id), 32'(e_id));
      checkField("rd_last", 32'(bus_if.rd_last), 32'(e_last));
    end
  endtask

  task automatic modelAdvance();
    int idx;
    if (rst) begin
      rem = 0; m_last = 1'b1;
      e_vld = 1'b0; e_data = '0; e_id = 1'b0; e_last = 1'b0;
    end else if (rem > 0) begin
      idx    = int'(m_len) + 1 - rem;
      e_vld  = 1'b1;
      e_data = rom_byte(4'((int'(m_base) + idx) % 16));
      e_id   = m_id;
      e_last = (rem == 1);
      rem--;
    end else begin
      e_vld = 1'b0; e_data = '0; e_id = 1'b0; e_last = 1'b0;
      if (m_g0 || m_g1) begin
        m_id   = m_win;
        m_last = m_win;
        m_base = m_win ? bus_if.addr1 : bus_if.addr0;
        m_len  = m_win ? bus_if.len1 : bus_if.len0;
        rem    = int'(m_len) + 1;
      end
    end
  endtask

  // One clock: sample mid-cycle, check, advance the model, return just after the next edge.
  task automatic stepCycle(input bit use_vec, input logic [19:0] exp_vec, input int vnum);
    @(negedge clk);
    checkOutput();
    if (use_vec) begin
      checkField($sformatf("vec%0d", vnum), 32'(dut_out()), 32'(exp_vec));
    end
    seen_g0 = bus_if.gnt0; seen_g1 = bus_if.gnt1;
    seen_vld = bus_if.rd_vld; seen_id = bus_if.rd_id; seen_data = bus_if.rd_data;
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus_if.req0 = 1'b0; bus_if.addr0 = '0; bus_if.len0 = '0;
    bus_if.req1 = 1'b0; bus_if.addr1 = '0; bus_if.len1 = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int next_id, ngr, nvld;
    bit found;

    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 0, 0, 0, 8'h00, 0, 0));
    addVec(1, 7, 0, 0, 0, 0, pack_out(1, 0, 0, 0, 0, 8'h00, 0, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 1, 7, 0, 8'h00, 0, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 0, 0, 1, 8'h77, 0, 1));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 0, 0, 0, 8'h00, 0, 0));
    addVec(0, 0, 0, 1, 14, 3, pack_out(0, 1, 0, 0, 0, 8'h00, 0, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 1, 14, 0, 8'h00, 0, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 1, 15, 1, 8'hEE, 1, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 1, 0, 1, 8'hFF, 1, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 1, 1, 1, 8'h00, 1, 0));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 0, 0, 1, 8'h11, 1, 1));
    addVec(0, 0, 0, 0, 0, 0, pack_out(0, 0, 0, 0, 0, 8'h00, 0, 0));

    rst = 1'b1;
    idleInputs();
    #1;
    stepCycle(0, '0, 0);
    stepCycle(0, '0, 0);
    rst = 1'b0;
    do_check = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      stepCycle(1, vecs[i].exp_out, i);
    end

    // Continuous contention: grants must alternate starting with requester 0.
    $display("[TB] alternating contention");
    bus_if.req0 = 1; bus_if.addr0 = 0; bus_if.len0 = 1;
    bus_if.req1 = 1; bus_if.addr1 = 8; bus_if.len1 = 1;
    next_id = 0; ngr = 0;
    for (int i = 0; i < 12; i++) begin
      stepCycle(0, '0, 0);
      if (seen_g0 || seen_g1) begin
        checkField("alt_grant_id", 32'(seen_g1), 32'(next_id));
        next_id ^= 1;
        ngr++;
      end
    end
    checkField("alt_grant_count", 32'(ngr), 32'd4);
    idleInputs();
    for (int i = 0; i < 4; i++) stepCycle(0, '0, 0);

    // Reset during the third beat of a 16-byte burst.
    $display("[TB] reset mid-burst");
    bus_if.req0 = 1; bus_if.addr0 = 5; bus_if.len0 = 15;
    stepCycle(0, '0, 0);
    idleInputs();
    for (int i = 0; i < 3; i++) stepCycle(0, '0, 0);
    rst = 1'b1;
    stepCycle(0, '0, 0);
    rst = 1'b0;
    @(negedge clk);
    checkField("rst_abort_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;
    nvld = 0;
    for (int i = 0; i < 5; i++) begin
      stepCycle(0, '0, 0);
      if (seen_vld) nvld++;
    end
    checkField("rst_no_vld", 32'(nvld), 32'd0);

    // addr0 changes while requester 1 is busy; the value present at gnt0 must be used.
    $display("[TB] address sampled at grant");
    bus_if.req1 = 1; bus_if.addr1 = 2; bus_if.len1 = 3;
    stepCycle(0, '0, 0);
    bus_if.req1 = 0;
    bus_if.req0 = 1; bus_if.addr0 = 3; bus_if.len0 = 0;
    stepCycle(0, '0, 0);
    bus_if.addr0 = 9;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      stepCycle(0, '0, 0);
      found = seen_g0;
    end
    checkField("sampled_addr_gnt0_seen", 32'(found), 32'd1);
    bus_if.req0 = 0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      stepCycle(0, '0, 0);
      if (seen_vld && seen_id == 1'b0) begin
        found = 1'b1;
        checkField("sampled_addr_data", 32'(seen_data), 32'h99);
      end
    end
    checkField("sampled_addr_beat_seen", 32'(found), 32'd1);
    idleInputs();
    for (int i = 0; i < 3; i++) stepCycle(0, '0, 0);

    // Randomized traffic obeying the hold-until-grant protocol, with rare resets.
    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(63, 0) == 0);
      if (m_g0) begin
        bus_if.req0 = 1'($urandom_range(1, 0));
        bus_if.addr0 = 4'($urandom); bus_if.len0 = 4'($urandom);
      end else if (!bus_if.req0) begin
        if ($urandom_range(2, 0) == 0) begin
          bus_if.req0 = 1; bus_if.addr0 = 4'($urandom); bus_if.len0 = 4'($urandom);
        end
      end else if ($urandom_range(3, 0) == 0) begin
        bus_if.addr0 = 4'($urandom);
      end
      if (m_g1) begin
        bus_if.req1 = 1'($urandom_range(1, 0));
        bus_if.addr1 = 4'($urandom); bus_if.len1 = 4'($urandom);
      end else if (!bus_if.req1) begin
        if ($urandom_range(2, 0) == 0) begin
          bus_if.req1 = 1; bus_if.addr1 = 4'($urandom); bus_if.len1 = 4'($urandom);
        end
      end else if ($urandom_range(3, 0) == 0) begin
        bus_if.addr1 = 4'($urandom);
      end
      stepCycle(0, '0, 0);
    end
    rst = 1'b0;
    idleInputs();
    for (int i = 0; i < 20; i++) stepCycle(0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
